// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit add/subtract unit between two requesters.
// Operands are latched on accept, evaluated for one cycle, and the result is held until taken.
module addsub_arbiter #(
   parameter int unsigned WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_sub,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_sub,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_overflow,
   output logic             busy
);

   typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

   state_e           state_q, state_d;
   logic             last_grant_q, last_grant_d;
   logic [WIDTH-1:0] op_a_q, op_a_d;
   logic [WIDTH-1:0] op_b_q, op_b_d;
   logic             op_sub_q, op_sub_d;
   logic             op_id_q, op_id_d;
   logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
   logic             rsp_overflow_q, rsp_overflow_d;
   logic             rsp_id_q, rsp_id_d;

   logic             grant0, grant1;
   logic [WIDTH-1:0] b_eff, sum;
   logic             ovf;

   // Port 0 wins alone, or under contention when port 1 was granted last.
   always_comb begin
      grant0 = req0_valid & (~req1_valid | last_grant_q);
      grant1 = req1_valid & ~grant0;
   end

   // Subtraction as A + ~B + 1; overflow when effective operands agree in sign but the sum does not.
   always_comb begin
      b_eff = op_sub_q ? ~op_b_q : op_b_q;
      sum   = op_a_q + b_eff + {{(WIDTH-1){1'b0}}, op_sub_q};
      ovf   = (op_a_q[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != op_a_q[WIDTH-1]);
   end

   always_comb begin
      state_d        = state_q;
      last_grant_d   = last_grant_q;
      op_a_d         = op_a_q;
      op_b_d         = op_b_q;
      op_sub_d       = op_sub_q;
      op_id_d        = op_id_q;
      rsp_result_d   = rsp_result_q;
      rsp_overflow_d = rsp_overflow_q;
      rsp_id_d       = rsp_id_q;
      unique case (state_q)
         StIdle: begin
            if (grant0 | grant1) begin
               op_a_d       = grant1 ? req1_a : req0_a;
               op_b_d       = grant1 ? req1_b : req0_b;
               op_sub_d     = grant1 ? req1_sub : req0_sub;
               op_id_d      = grant1;
               last_grant_d = grant1;
               state_d      = StExec;
            end
         end
         StExec: begin
            rsp_result_d   = sum;
            rsp_overflow_d = ovf;
            rsp_id_d       = op_id_q;
            state_d        = StResp;
         end
         StResp: begin
            if (rsp_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= StIdle;
         last_grant_q   <= 1'b1;
         op_a_q         <= '0;
         op_b_q         <= '0;
         op_sub_q       <= 1'b0;
         op_id_q        <= 1'b0;
         rsp_result_q   <= '0;
         rsp_overflow_q <= 1'b0;
         rsp_id_q       <= 1'b0;
      end else begin
         state_q        <= state_d;
         last_grant_q   <= last_grant_d;
         op_a_q         <= op_a_d;
         op_b_q         <= op_b_d;
         op_sub_q       <= op_sub_d;
         op_id_q        <= op_id_d;
         rsp_result_q   <= rsp_result_d;
         rsp_overflow_q <= rsp_overflow_d;
         rsp_id_q       <= rsp_id_d;
      end
   end

   always_comb begin
      req0_ready   = (state_q == StIdle) & grant0;
      req1_ready   = (state_q == StIdle) & grant1;
      rsp_valid    = (state_q == StResp);
      busy         = (state_q != StIdle);
      rsp_id       = rsp_id_q;
      rsp_result   = rsp_result_q;
      rsp_overflow = rsp_overflow_q;
   end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed and randomized checks of addsub_arbiter against an integer-arithmetic reference model.
module tb_addsub_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req0_ready, req0_sub;
   logic [63:0] req0_a, req0_b;
   logic        req1_valid, req1_ready, req1_sub;
   logic [63:0] req1_a, req1_b;
   logic        rsp_valid, rsp_ready, rsp_id, rsp_overflow, busy;
   logic [63:0] rsp_result;

   int total = 0;
   int bad   = 0;
   logic model_last;  // requester granted most recently

   localparam logic [63:0] MinV = 64'h8000_0000_0000_0000;
   localparam logic [63:0] MaxV = 64'h7FFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] AllOnes = 64'hFFFF_FFFF_FFFF_FFFF;

   addsub_arbiter #(.WIDTH(64)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req0_sub(req0_sub),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .req1_sub(req1_sub),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
      .rsp_overflow(rsp_overflow), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Exact signed arithmetic in 66 bits; overflow means the true value leaves the 64-bit range.
   task automatic model(input logic [63:0] a, input logic [63:0] b, input logic sub,
                        output logic [63:0] r, output logic o);
      logic signed [65:0] ea, eb, full, hi, lo;
      ea   = {{2{a[63]}}, a};
      eb   = {{2{b[63]}}, b};
      full = sub ? (ea - eb) : (ea + eb);
      hi   = (66'sd1 <<< 63) - 66'sd1;
      lo   = -(66'sd1 <<< 63);
      r    = full[63:0];
      o    = (full > hi) || (full < lo);
   endtask

   // Entered and left at a falling edge with the DUT idle; rsp_ready held low k cycles in RESP.
   task automatic do_op(input string tag,
                        input logic v0, input logic [63:0] a0, input logic [63:0] b0,
                        input logic s0,
                        input logic v1, input logic [63:0] a1, input logic [63:0] b1,
                        input logic s1, input int k);
      logic        win;
      logic [63:0] er;
      logic        eo;
      req0_valid = v0; req0_a = a0; req0_b = b0; req0_sub = s0;
      req1_valid = v1; req1_a = a1; req1_b = b1; req1_sub = s1;
      rsp_ready  = (k == 0);
      #1;
      win = (v0 && v1) ? ~model_last : v1;
      if (win) model(a1, b1, s1, er, eo);
      else     model(a0, b0, s0, er, eo);
      chk({tag, ".idle_busy"}, 64'(busy), 64'(0));
      chk({tag, ".ready0"}, 64'(req0_ready), 64'(!win));
      chk({tag, ".ready1"}, 64'(req1_ready), 64'(win));
      model_last = win;
      @(negedge clk);
      chk({tag, ".exec_busy"}, 64'(busy), 64'(1));
      chk({tag, ".exec_rspv"}, 64'(rsp_valid), 64'(0));
      chk({tag, ".exec_ready"}, 64'({req0_ready, req1_ready}), 64'(0));
      // Winner withdraws and scribbles its operands; the in-flight result must not notice.
      if (win) begin req1_valid = 1'b0; req1_a = {$urandom, $urandom}; req1_b = ~req1_b; end
      else     begin req0_valid = 1'b0; req0_a = {$urandom, $urandom}; req0_b = ~req0_b; end
      @(negedge clk);
      for (int i = 0; i <= k; i++) begin
         chk({tag, ".rsp_valid"}, 64'(rsp_valid), 64'(1));
         chk({tag, ".rsp_id"}, 64'(rsp_id), 64'(win));
         chk({tag, ".rsp_result"}, rsp_result, er);
         chk({tag, ".rsp_ovf"}, 64'(rsp_overflow), 64'(eo));
         chk({tag, ".resp_ready"}, 64'({req0_ready, req1_ready}), 64'(0));
         chk({tag, ".resp_busy"}, 64'(busy), 64'(1));
         if (i < k) @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      logic [63:0] ra, rb;
      logic        rs, rv0, rv1;
      rst = 1'b1;
      req0_valid = 0; req0_a = 0; req0_b = 0; req0_sub = 0;
      req1_valid = 0; req1_a = 0; req1_b = 0; req1_sub = 0;
      rsp_ready  = 1'b1;
      model_last = 1'b1;
      #1;
      chk("reset.rsp_valid", 64'(rsp_valid), 64'(0));
      chk("reset.rsp_id", 64'(rsp_id), 64'(0));
      chk("reset.rsp_result", rsp_result, 64'(0));
      chk("reset.rsp_ovf", 64'(rsp_overflow), 64'(0));
      chk("reset.busy", 64'(busy), 64'(0));
      chk("reset.ready", 64'({req0_ready, req1_ready}), 64'(0));
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("idle.rsp_valid", 64'(rsp_valid), 64'(0));

      do_op("sub_max_m1", 1, MaxV, AllOnes, 1, 0, 0, 0, 0, 0);
      do_op("sub_min_min", 1, MinV, MinV, 1, 0, 0, 0, 0, 0);
      do_op("sub_1_m1", 0, 0, 0, 0, 1, 64'd1, AllOnes, 1, 0);
      do_op("sub_m1_m1", 1, AllOnes, AllOnes, 1, 0, 0, 0, 0, 0);
      do_op("add_max_1", 1, MaxV, 64'd1, 0, 0, 0, 0, 0, 0);
      do_op("add_min_min", 0, 0, 0, 0, 1, MinV, MinV, 0, 0);

      // Continuous contention: grants alternate and each follows 3 cycles after the last.
      for (int i = 0; i < 4; i++)
         do_op("contend", 1, 64'd100 + 64'(i), 64'd7, 0, 1, 64'd200 + 64'(i), 64'd9, 1, 0);

      // Backpressure while the losing port stays valid.
      do_op("bp", 1, 64'h1234, 64'h4321, 0, 1, 64'hAAAA, 64'h5555, 1, 5);
      do_op("bp_next", 1, 64'h1234, 64'h4321, 0, 0, 0, 0, 0, 0);

      for (int i = 0; i < 20; i++) begin
         ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
         rs = 1'($urandom); rv0 = 1'($urandom); rv1 = 1'($urandom);
         if (!rv0 && !rv1) rv0 = 1'b1;
         do_op("rand", rv0, ra, rb, rs, rv1, ~ra, rb ^ 64'h5A5A, ~rs,
               int'($urandom_range(0, 2)));
      end

      // Reset mid-EXEC drops the operation and restores the initial arbitration priority.
      req0_valid = 1; req0_a = 64'd5; req0_b = 64'd3; req0_sub = 0;
      req1_valid = 0;
      #1;
      chk("rst.accept", 64'(req0_ready), 64'(1));
      @(negedge clk);
      req0_valid = 0;
      rst = 1'b1;
      #1;
      chk("rst.rsp_valid", 64'(rsp_valid), 64'(0));
      chk("rst.busy", 64'(busy), 64'(0));
      chk("rst.rsp_result", rsp_result, 64'(0));
      @(negedge clk);
      rst = 1'b0;
      model_last = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rst.no_rsp", 64'(rsp_valid), 64'(0));
      end
      do_op("rst.contend", 1, 64'd11, 64'd22, 0, 1, 64'd33, 64'd44, 1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/addsub_arbiter.md
# addsub_arbiter

Shares the single 64-bit add/subtract unit (ADD_64/SUB_64 datapath) between two requesters in the sequential RISC-V core: port 0 (execute-stage ALU ops) and port 1 (branch-compare / address generation). It arbitrates round-robin, latches operands, drives the shared unit for one cycle, and registers the result and signed-overflow flag. The result is held on a single response port, tagged with the requester id, until it is accepted.

## Interface
- WIDTH, 64, operand/result width in bits

- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- req0_valid  input  1  port 0 has an operation
- req0_ready  output  1  port 0 operation accepted this cycle
- req0_a  input  WIDTH  port 0 operand A (two's complement)
- req0_b  input  WIDTH  port 0 operand B
- req0_sub  input  1  port 0: 1 = A−B, 0 = A+B
- req1_valid / req1_ready / req1_a / req1_b / req1_sub  same as port 0, for port 1
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer accepts result
- rsp_id  output  1  requester that owns the result (0 or 1)
- rsp_result  output  WIDTH  A±B modulo 2^WIDTH
- rsp_overflow  output  1  signed overflow of the operation
- busy  output  1  high in any state other than IDLE

## Operation
- States: IDLE, EXEC, RESP.
- IDLE:
  - reqN_ready = grant & reqN_valid, combinational.
  - If any valid, grant one requester, latch a, b, sub and id into operand registers, then go to EXEC.
  - No valid: stay in IDLE.
- Arbitration:
  - One requester valid: that requester wins.
  - Both valid: the winner is the port not granted last time.
  - last_grant resets to 1, so port 0 wins the first contention.
  - last_grant updates only on an accept.
- EXEC: the shared unit evaluates the latched operands. At the clock edge, register result, overflow and id, then go to RESP.
- RESP:
  - rsp_valid = 1; outputs are stable.
  - rsp_ready = 1: go to IDLE.
  - Otherwise hold indefinitely with no change to any rsp_* output.
- Both reqN_ready are 0 outside IDLE. Requests arriving in EXEC/RESP wait; requesters must hold valid and operands until ready.
- Arithmetic:
  - sub=1: result = A + ~B + 1. sub=0: result = A + B. Carry out is discarded.
  - Overflow (add) = (A[W−1]==B[W−1]) & (R[W−1]!=A[W−1]).
  - Overflow (sub) = (A[W−1]!=B[W−1]) & (R[W−1]!=A[W−1]).
- Reset (asynchronous, any state, including mid-EXEC or mid-RESP):
  - State = IDLE; last_grant = 1; all operand and response registers = 0.
  - An in-flight operation is dropped and no response is produced.
- Reset values of outputs: req0_ready = req1_ready = 0 (unless valid is already asserted in IDLE), rsp_valid = 0, rsp_id = 0, rsp_result = 0, rsp_overflow = 0, busy = 0.

## Timing
- Accept at edge T (valid & ready high in the cycle before T). State is EXEC in cycle T to T+1. rsp_valid rises after edge T+1, so latency is 2 cycles from accept to rsp_valid.
- Result accepted at edge T+2 (rsp_ready already high) → IDLE in the next cycle → next accept at edge T+3 at the earliest. Peak throughput is 1 op per 3 cycles.
- rsp_ready low for k cycles extends RESP by k cycles. Nothing else changes.
- rsp_ready is ignored outside RESP. An asserted rsp_ready with rsp_valid low has no effect.
- Operand changes after acceptance do not affect the in-flight result.

## Test plan
- Reset then idle: all outputs 0. req0 (sub=1, A=0x7FFF_FFFF_FFFF_FFFF, B=0xFFFF_FFFF_FFFF_FFFF) → req0_ready for 1 cycle; 2 cycles later rsp_valid=1, rsp_id=0, rsp_result=0x8000_0000_0000_0000, rsp_overflow=1.
- Sub corner cases:
  - A=B=0x8000_0000_0000_0000 → result 0, overflow 0.
  - A=1, B=0xFFFF_FFFF_FFFF_FFFF → result 2, overflow 0.
  - A=B=0xFFFF_FFFF_FFFF_FFFF → result 0, overflow 0.
- Add: A=0x7FFF_FFFF_FFFF_FFFF, B=1, sub=0 → result 0x8000_0000_0000_0000, overflow 1. A=B=0x8000_0000_0000_0000 → result 0, overflow 1.
- Contention: req0 and req1 held valid continuously → grants alternate 0,1,0,1. rsp_id follows the same sequence, with 3-cycle spacing between grants.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP → rsp_* stable, both ready low, busy=1. Raise rsp_ready → IDLE next cycle and the pending request is accepted.
- Assert rst during EXEC → immediately rsp_valid=0, busy=0. No response appears after rst is released, and the first contention grants port 0.
